// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one byte-wide UART transmitter between NREQ sources,
// with burst locking and a watchdog that frees the transmitter on a stalled byte or burst.
module uart_tx_sched #(
  parameter int NREQ = 4,
  parameter int TO_W = 20
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  input  logic [NREQ-1:0]   req_last,
  output logic [NREQ-1:0]   req_ready,
  output logic [7:0]        tx_data,
  output logic              tx_wr,
  input  logic              tx_done,
  output logic [NREQ-1:0]   grant,
  output logic              busy,
  output logic              err_timeout,
  output logic [1:0]        state_dbg
);

  // Handshake: a byte moves when req_ready[i] pulses; until then the requester keeps
  // req_data/req_last stable while req_valid is high, or withdraws by dropping req_valid.

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   owner;
  logic            lock;
  logic [TO_W-1:0] wd;

  logic            pick_found;
  logic [PW-1:0]   pick_idx;
  logic [PW:0]     scan;

  logic            issue;
  logic [PW-1:0]   issue_idx;
  logic            release_grant;
  logic            timeout;
  logic            wd_expired;

  // First valid requester scanning rr_ptr, rr_ptr+1, ... modulo NREQ.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    scan       = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan = {1'b0, rr_ptr} + (PW+1)'(i);
      if (scan >= (PW+1)'(NREQ)) scan = scan - (PW+1)'(NREQ);
      if (!pick_found && req_valid[scan[PW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = scan[PW-1:0];
      end
    end
  end

  assign wd_expired = (wd == {TO_W{1'b1}});

  // Next-state and transfer decisions.
  always_comb begin
    state_d       = state;
    issue         = 1'b0;
    issue_idx     = pick_idx;
    release_grant = 1'b0;
    timeout       = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          issue   = 1'b1;
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (tx_done) begin
          if (lock) begin
            state_d = HOLD;
          end else begin
            release_grant = 1'b1;
            state_d       = IDLE;
          end
        end else if (wd_expired) begin
          timeout       = 1'b1;
          release_grant = 1'b1;
          state_d       = IDLE;
        end
      end
      HOLD: begin
        if (req_valid[owner]) begin
          issue     = 1'b1;
          issue_idx = owner;
          state_d   = WAIT;
        end else if (wd_expired) begin
          timeout       = 1'b1;
          release_grant = 1'b1;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      owner     <= '0;
      lock      <= 1'b0;
      wd        <= '0;
      tx_data   <= 8'h00;
      tx_wr     <= 1'b0;
      req_ready <= '0;
      grant     <= '0;
      busy      <= 1'b0;
    end else begin
      state     <= state_d;
      tx_wr     <= issue;
      req_ready <= issue ? (NREQ'(1) << issue_idx) : '0;
      busy      <= (state_d != IDLE);
      if (issue) begin
        tx_data <= req_data[{issue_idx, 3'b000} +: 8];
        grant   <= NREQ'(1) << issue_idx;
        owner   <= issue_idx;
        lock    <= ~req_last[issue_idx];
      end
      if (release_grant) begin
        grant  <= '0;
        lock   <= 1'b0;
        rr_ptr <= (owner == PW'(NREQ-1)) ? '0 : owner + 1'b1;
      end
      // Every entry into WAIT or HOLD restarts the watchdog.
      if (state_d != state || state == IDLE) begin
        wd <= '0;
      end else begin
        wd <= wd + 1'b1;
      end
    end
  end

  // Expiry is flagged in the cycle the watchdog sits at all-ones; tx_done in that cycle wins.
  always_comb begin
    err_timeout = timeout;
    state_dbg   = state;
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched: single byte, fairness, burst lock,
// WAIT/HOLD watchdog expiry and reset in the middle of a burst.
module tb_uart_tx_sched;

  localparam int NREQ = 4;
  localparam int TO_W = 4;

  logic              sys_clk = 1'b0;
  logic              sys_rst_n;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_data;
  logic [NREQ-1:0]   req_last;
  logic [NREQ-1:0]   req_ready;
  logic [7:0]        tx_data;
  logic              tx_wr;
  logic              tx_done;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              err_timeout;
  logic [1:0]        state_dbg;

  int n_checks = 0;
  int n_fail   = 0;

  uart_tx_sched #(.NREQ(NREQ), .TO_W(TO_W)) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .req_valid   (req_valid),
    .req_data    (req_data),
    .req_last    (req_last),
    .req_ready   (req_ready),
    .tx_data     (tx_data),
    .tx_wr       (tx_wr),
    .tx_done     (tx_done),
    .grant       (grant),
    .busy        (busy),
    .err_timeout (err_timeout),
    .state_dbg   (state_dbg)
  );

  // Clock and safety bound.
  always #5 sys_clk = ~sys_clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: simulation exceeded time limit");
    $fatal(1, "time limit");
  end

  // Driver tasks: inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(negedge sys_clk);
  endtask

  task automatic set_req(input int i, input logic [7:0] d, input logic last);
    req_data[i*8 +: 8] = d;
    req_last[i]        = last;
    req_valid[i]       = 1'b1;
  endtask

  task automatic drop_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic test_reset();
    sys_rst_n = 1'b0;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    tx_done   = 1'b0;
    tick();
    req_valid = 4'b1111;
    tick();
    n_checks++; if (tx_wr !== 1'b0) begin n_fail++; $display("FAIL reset_tx_wr: got %b want 0", tx_wr); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h want 00", tx_data); end
    n_checks++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
    n_checks++; if (grant !== 4'b0000) begin n_fail++; $display("FAIL reset_grant: got %b want 0000", grant); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (err_timeout !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", err_timeout); end
    n_checks++; if (state_dbg !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_dbg); end
    req_valid = '0;
    sys_rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    set_req(2, 8'h41, 1'b1);
    tick();
    n_checks++; if (tx_wr !== 1'b1) begin n_fail++; $display("FAIL single_tx_wr: got %b want 1", tx_wr); end
    n_checks++; if (req_ready !== 4'b0100) begin n_fail++; $display("FAIL single_ready: got %b want 0100", req_ready); end
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data: got %h want 41", tx_data); end
    n_checks++; if (grant !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b want 0100", grant); end
    n_checks++; if (busy !== 1'b1 || state_dbg !== 2'd1) begin n_fail++; $display("FAIL single_busy: got busy=%b state=%0d want 1/1", busy, state_dbg); end
    drop_req(2);
    tick();
    n_checks++; if (tx_wr !== 1'b0 || req_ready !== 4'b0000) begin n_fail++; $display("FAIL single_pulse_width: got wr=%b ready=%b want 0/0000", tx_wr, req_ready); end
    n_checks++; if (grant !== 4'b0100 || tx_data !== 8'h41) begin n_fail++; $display("FAIL single_hold: got grant=%b data=%h want 0100/41", grant, tx_data); end
    tick();
    tick();
    pulse_done();
    n_checks++; if (grant !== 4'b0000 || busy !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL single_idle: got grant=%b busy=%b state=%0d want 0000/0/0", grant, busy, state_dbg); end
    // rr_ptr is now 3: with everyone valid, requester 3 wins.
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'hA0 + i), 1'b1);
    tick();
    n_checks++; if (grant !== 4'b1000 || tx_data !== 8'hA3) begin n_fail++; $display("FAIL single_rr_ptr3: got grant=%b data=%h want 1000/a3", grant, tx_data); end
    req_valid = '0;
    tick();
    pulse_done();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_end_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_fairness();
    int exp_order[6] = '{0, 1, 2, 3, 0, 1};
    int cnt[4]       = '{0, 0, 0, 0};
    int k;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'(8'h10 + i), 1'b1);
    tick();
    for (int r = 0; r < 6; r++) begin
      k = exp_order[r];
      n_checks++; if (tx_wr !== 1'b1 || grant !== 4'(1 << k) || tx_data !== 8'(8'h10 + k)) begin
        n_fail++; $display("FAIL fair_round%0d: got wr=%b grant=%b data=%h want 1/%b/%h", r, tx_wr, grant, tx_data, 4'(1 << k), 8'(8'h10 + k));
      end
      for (int j = 0; j < NREQ; j++) if (req_ready[j] === 1'b1) cnt[j]++;
      for (int c = 0; c < 9; c++) begin
        tick();
        for (int j = 0; j < NREQ; j++) if (req_ready[j] === 1'b1) cnt[j]++;
      end
      pulse_done();
      n_checks++; if (tx_wr !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL fair_gap%0d: got wr=%b busy=%b want 0/0", r, tx_wr, busy); end
      if (r == 5) req_valid = '0;
      tick();
    end
    n_checks++; if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 1 || cnt[3] != 1) begin
      n_fail++; $display("FAIL fair_ready_count: got %0d %0d %0d %0d want 2 2 1 1", cnt[0], cnt[1], cnt[2], cnt[3]);
    end
    n_checks++; if (busy !== 1'b0 || tx_wr !== 1'b0) begin n_fail++; $display("FAIL fair_end_idle: got busy=%b wr=%b want 0/0", busy, tx_wr); end
  endtask

  task automatic test_burst_lock();
    set_req(1, 8'h1a, 1'b0);
    tick();
    n_checks++; if (grant !== 4'b0010 || tx_data !== 8'h1a || req_ready !== 4'b0010) begin n_fail++; $display("FAIL burst_a: got grant=%b data=%h ready=%b want 0010/1a/0010", grant, tx_data, req_ready); end
    set_req(1, 8'h1b, 1'b0);
    set_req(0, 8'h30, 1'b1);
    set_req(3, 8'h33, 1'b1);
    tick();
    tick();
    pulse_done();
    n_checks++; if (state_dbg !== 2'd2 || grant !== 4'b0010 || tx_wr !== 1'b0) begin n_fail++; $display("FAIL burst_hold: got state=%0d grant=%b wr=%b want 2/0010/0", state_dbg, grant, tx_wr); end
    tick();
    n_checks++; if (tx_wr !== 1'b1 || tx_data !== 8'h1b || req_ready !== 4'b0010) begin n_fail++; $display("FAIL burst_b: got wr=%b data=%h ready=%b want 1/1b/0010", tx_wr, tx_data, req_ready); end
    set_req(1, 8'h1c, 1'b1);
    tick();
    tick();
    pulse_done();
    tick();
    n_checks++; if (tx_wr !== 1'b1 || tx_data !== 8'h1c || grant !== 4'b0010) begin n_fail++; $display("FAIL burst_c: got wr=%b data=%h grant=%b want 1/1c/0010", tx_wr, tx_data, grant); end
    drop_req(1);
    tick();
    pulse_done();
    tick();
    n_checks++; if (grant !== 4'b1000 || tx_data !== 8'h33) begin n_fail++; $display("FAIL burst_next3: got grant=%b data=%h want 1000/33", grant, tx_data); end
    drop_req(3);
    tick();
    pulse_done();
    tick();
    n_checks++; if (grant !== 4'b0001 || tx_data !== 8'h30) begin n_fail++; $display("FAIL burst_next0: got grant=%b data=%h want 0001/30", grant, tx_data); end
    drop_req(0);
    tick();
    pulse_done();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL burst_end_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_timeout_wait();
    logic early;
    set_req(1, 8'h51, 1'b1);
    set_req(2, 8'h52, 1'b1);
    tick();
    n_checks++; if (grant !== 4'b0010 || tx_wr !== 1'b1) begin n_fail++; $display("FAIL wto_issue: got grant=%b wr=%b want 0010/1", grant, tx_wr); end
    set_req(1, 8'h61, 1'b1);
    early = 1'b0;
    for (int c = 1; c < 15; c++) begin
      tick();
      if (err_timeout !== 1'b0 || tx_wr !== 1'b0) early = 1'b1;
    end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL wto_early: got early err/wr=%b want 0", early); end
    tick();
    n_checks++; if (err_timeout !== 1'b1 || grant !== 4'b0010) begin n_fail++; $display("FAIL wto_fire: got err=%b grant=%b want 1/0010", err_timeout, grant); end
    tick();
    n_checks++; if (err_timeout !== 1'b0 || grant !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL wto_release: got err=%b grant=%b busy=%b want 0/0000/0", err_timeout, grant, busy); end
    tick();
    n_checks++; if (grant !== 4'b0100 || tx_data !== 8'h52) begin n_fail++; $display("FAIL wto_next: got grant=%b data=%h want 0100/52", grant, tx_data); end
    drop_req(1);
    drop_req(2);
    tick();
    pulse_done();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL wto_end_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_stalled_burst();
    logic bad;
    set_req(2, 8'h71, 1'b0);
    tick();
    n_checks++; if (grant !== 4'b0100 || tx_data !== 8'h71) begin n_fail++; $display("FAIL stall_issue: got grant=%b data=%h want 0100/71", grant, tx_data); end
    drop_req(2);
    set_req(0, 8'h81, 1'b1);
    tick();
    pulse_done();
    n_checks++; if (state_dbg !== 2'd2 || busy !== 1'b1) begin n_fail++; $display("FAIL stall_hold: got state=%0d busy=%b want 2/1", state_dbg, busy); end
    bad = 1'b0;
    for (int c = 1; c < 15; c++) begin
      tick();
      if (err_timeout !== 1'b0 || tx_wr !== 1'b0) bad = 1'b1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL stall_hold_quiet: got early err/wr=%b want 0", bad); end
    tick();
    n_checks++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL stall_fire: got err=%b want 1", err_timeout); end
    tick();
    n_checks++; if (grant !== 4'b0000 || busy !== 1'b0 || err_timeout !== 1'b0) begin n_fail++; $display("FAIL stall_release: got grant=%b busy=%b err=%b want 0000/0/0", grant, busy, err_timeout); end
    tick();
    n_checks++; if (grant !== 4'b0001 || tx_data !== 8'h81 || tx_wr !== 1'b1) begin n_fail++; $display("FAIL stall_next0: got grant=%b data=%h wr=%b want 0001/81/1", grant, tx_data, tx_wr); end
    drop_req(0);
    tick();
    pulse_done();
    n_checks++; if (busy !== 1'b0 || grant !== 4'b0000) begin n_fail++; $display("FAIL stall_unlocked: got busy=%b grant=%b want 0/0000", busy, grant); end
  endtask

  task automatic test_reset_midburst();
    set_req(3, 8'h91, 1'b0);
    tick();
    n_checks++; if (grant !== 4'b1000) begin n_fail++; $display("FAIL rst_issue: got grant=%b want 1000", grant); end
    drop_req(3);
    tick();
    sys_rst_n = 1'b0;
    tick();
    n_checks++; if (tx_wr !== 1'b0 || tx_data !== 8'h00 || grant !== 4'b0000 || busy !== 1'b0 || req_ready !== 4'b0000 || err_timeout !== 1'b0) begin
      n_fail++; $display("FAIL rst_outputs: got wr=%b data=%h grant=%b busy=%b ready=%b err=%b want all zero", tx_wr, tx_data, grant, busy, req_ready, err_timeout);
    end
    sys_rst_n = 1'b1;
    tick();
    pulse_done();
    n_checks++; if (busy !== 1'b0 || grant !== 4'b0000 || tx_wr !== 1'b0 || state_dbg !== 2'd0) begin n_fail++; $display("FAIL rst_late_done: got busy=%b grant=%b wr=%b state=%0d want 0/0000/0/0", busy, grant, tx_wr, state_dbg); end
    set_req(0, 8'hb0, 1'b1);
    set_req(3, 8'hb3, 1'b1);
    tick();
    n_checks++; if (grant !== 4'b0001 || tx_data !== 8'hb0) begin n_fail++; $display("FAIL rst_rr_ptr0: got grant=%b data=%h want 0001/b0", grant, tx_data); end
    drop_req(0);
    drop_req(3);
    tick();
    pulse_done();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_burst_lock();
    test_timeout_wait();
    test_stalled_burst();
    test_reset_midburst();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
Name: uart_tx_sched

Overview:
- Round-robin scheduler that shares one UART transmitter (tx_data/tx_wr/tx_done byte interface) between NREQ independent byte sources.
- Supports multi-byte bursts: a requester holds the transmitter until it marks a byte as last.
- A watchdog recovers from a missing tx_done or a stalled burst.
- Sits between the CSR/debug/console byte producers and the UART core.

Parameters:
- NREQ, 4, number of requesters (2..8)
- TO_W, 20, watchdog counter width; a timeout fires after 2^TO_W-1 cycles

Ports:
- sys_clk  in  1  system clock
- sys_rst_n  in  1  synchronous, active-low reset
- req_valid  in  NREQ  per-requester byte available
- req_data  in  8*NREQ  byte of requester i on bits [8i+7:8i]
- req_last  in  NREQ  byte is the final byte of a burst
- req_ready  out  NREQ  one-hot, 1-cycle pulse: byte of requester i accepted
- tx_data  out  8  byte to the UART; registered, stable from tx_wr until tx_done
- tx_wr  out  1  1-cycle write strobe to the UART
- tx_done  in  1  1-cycle pulse from the UART: byte fully sent
- grant  out  NREQ  one-hot owner of the transmitter; 0 when idle
- busy  out  1  the state is not IDLE
- err_timeout  out  1  1-cycle pulse on a watchdog expiry

Behaviour:
- Reset (sys_rst_n=0 at a clock edge): state=IDLE; tx_wr=0; tx_data=0; req_ready=0; grant=0; busy=0; err_timeout=0; rr_ptr=0; watchdog=0. Reset applied mid-byte abandons the byte silently. A tx_done arriving later in IDLE is ignored.
- States: IDLE, WAIT, HOLD.
- IDLE:
  - If any req_valid is set, pick the first set index scanning rr_ptr, rr_ptr+1, ... mod NREQ. Call it k.
  - Next edge: tx_data<=req_data[k]; tx_wr<=1; req_ready[k]<=1; grant<=onehot(k); lock<=~req_last[k]; state<=WAIT; watchdog cleared.
  - Latency from req_valid to tx_wr is exactly 1 cycle.
- tx_wr and req_ready are high for exactly one cycle, in the same cycle.
- Requester rule: req_data and req_last must stay stable while req_valid=1 and req_ready=0. Deasserting req_valid before req_ready is allowed (the request is withdrawn).
- WAIT:
  - Watchdog increments each cycle.
  - On tx_done with lock=1: state<=HOLD.
  - On tx_done with lock=0: grant<=0; rr_ptr<=(k+1) mod NREQ; state<=IDLE.
  - On watchdog all-ones without tx_done: err_timeout pulse, grant<=0, lock<=0, rr_ptr<=k+1, state<=IDLE. tx_done in the same cycle as expiry wins: no error.
- HOLD:
  - Only requester k is considered. Others are ignored even when valid.
  - On req_valid[k]: issue exactly as in IDLE (same 1-cycle latency); lock<=~req_last[k]; state<=WAIT.
  - Watchdog expiry with req_valid[k] low: err_timeout, release the grant, rr_ptr<=k+1, IDLE.
  - The watchdog restarts on every entry to WAIT or HOLD.
- No new tx_wr is ever issued while in WAIT; at most one byte is outstanding.
- tx_done in IDLE or HOLD is ignored.
- busy=(state!=IDLE); it is registered, so it rises with tx_wr.
- rr_ptr is log2(NREQ) bits wide and wraps NREQ-1 -> 0.
- Back-to-back single bytes: the IDLE arbitration in the cycle after tx_done gives a minimum gap of 1 cycle between tx_done and the next tx_wr.

Test Plan:
- Single byte: reset, req_valid[2]=1, data 0x41, last=1 -> tx_wr and req_ready[2] high one cycle later; tx_data=0x41; grant=0100 until tx_done; IDLE 1 cycle later; rr_ptr=3.
- Fairness: all four requesters valid, single bytes, UART model returns tx_done 10 cycles after tx_wr -> grant order 0,1,2,3,0,1; each req_ready pulses once per round.
- Burst lock: req 1 sends 3 bytes (last on the 3rd) while req 0 and req 3 are valid -> bytes 1a,1b,1c go consecutively; then req 3 is granted (rr_ptr=2 scan); then req 0.
- Timeout in WAIT: TO_W=4, no tx_done -> err_timeout pulses 15 cycles after entering WAIT; grant=0; the next requester is served.
- Stalled burst: req 2 sends a non-last byte, then drops req_valid -> after tx_done, HOLD for 15 cycles (TO_W=4); err_timeout; lock released; req 0 is served next.
- Reset mid-burst: sys_rst_n low during WAIT -> all outputs 0 next edge; a late tx_done is ignored; a fresh request is served from rr_ptr=0.
